// File: rtl/keypad_writer_pkg.sv
// ---------------------------------------------------------------------------
// keypad_writer_pkg
// Shared definitions for the 4x4 keypad scanner / FIFO byte writer:
//   - state_t    : scanner FSM state encoding
//   - COL_IDLE   : column drive with no column selected
//   - COL_START  : first column driven after reset (column 0 active-low)
//   - ROW_IDLE   : synchronized row pattern with no key pressed
//   - KEY_W      : width of a key code (row*4 + col)
//   - lowest_low : index of the lowest-numbered active-low row
//   - col_index  : index of the active-low column in a one-hot drive word
// ---------------------------------------------------------------------------
package keypad_writer_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] COL_START = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam int         KEY_W     = 4;

    // Scan from the top so the last hit (lowest index) wins.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_writer_scan_tick.sv
// ---------------------------------------------------------------------------
// scan_tick
// Free-running divider: counts 0..SCAN_DIV-1 and raises tick for the one
// cycle in which the counter wraps.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (counter -> 0)
//   tick  : one-cycle pulse every SCAN_DIV clocks
// ---------------------------------------------------------------------------
module scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_writer.sv
// ---------------------------------------------------------------------------
// keypad_writer
// Scans a 4x4 active-low keypad, debounces press and release, and packs two
// accepted key codes into one byte written to a downstream FIFO.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   row_in    : keypad rows, active-low, asynchronous
//   col_out   : column drive, active-low one-hot
//   fifo_full : FIFO full flag, checked in the cycle wr would be high
//   wr        : one-cycle FIFO write strobe (wr=1 only while fifo_full=0)
//   data_out  : assembled byte {first key, second key}
//   key_code  : last accepted key code (row*4 + col)
//   key_valid : one-cycle pulse per accepted key
//   half_byte : high nibble captured, low nibble pending
//   drop_err  : sticky, a byte was lost because the FIFO was full
//   fsm_state : current scanner state, for observation
//
// Handshake: a byte is offered for exactly one cycle after the second key of
// a pair; it is written when wr=1 (offer and not fifo_full) and dropped
// (drop_err set) when fifo_full=1 in that cycle. There is no retry.
// ---------------------------------------------------------------------------
module keypad_writer
    import keypad_writer_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    input  logic             fifo_full,
    output logic             wr,
    output logic [7:0]       data_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             half_byte,
    output logic             drop_err,
    output state_t           fsm_state
);

    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic [3:0]       row_meta, row_sync;
    logic             tick;
    state_t           state_q, state_nx;
    logic [3:0]       col_q, col_nx;
    logic [1:0]       row_idx_q, row_idx_nx;
    logic [1:0]       col_idx_q, col_idx_nx;
    logic [DW-1:0]    db_cnt_q, db_cnt_nx;
    logic             accept;
    logic [KEY_W-1:0] high_q;
    logic             byte_ready;

    // Two-flop synchronizer; idles at "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= ROW_IDLE;
            row_sync <= ROW_IDLE;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            col_q     <= COL_START;
            row_idx_q <= 2'd0;
            col_idx_q <= 2'd0;
            db_cnt_q  <= '0;
        end else begin
            state_q   <= state_nx;
            col_q     <= col_nx;
            row_idx_q <= row_idx_nx;
            col_idx_q <= col_idx_nx;
            db_cnt_q  <= db_cnt_nx;
        end
    end

    // Rows are only looked at on tick: the column has then been stable for
    // SCAN_DIV clocks, so the synchronized rows belong to the driven column.
    // col_out stays frozen outside SCAN, so only the latched column is seen.
    always_comb begin
        state_nx   = state_q;
        col_nx     = col_q;
        row_idx_nx = row_idx_q;
        col_idx_nx = col_idx_q;
        db_cnt_nx  = db_cnt_q;
        accept     = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (row_sync == ROW_IDLE) begin
                        col_nx = {col_q[2:0], col_q[3]};
                    end else begin
                        row_idx_nx = lowest_low(row_sync);
                        col_idx_nx = col_index(col_q);
                        db_cnt_nx  = '0;
                        state_nx   = ST_PRESS_DB;
                    end
                end
            end
            ST_PRESS_DB: begin
                if (tick) begin
                    if (!row_sync[row_idx_q]) begin
                        if (db_cnt_q == DB_LAST) begin
                            accept    = 1'b1;
                            db_cnt_nx = '0;
                            state_nx  = ST_HELD;
                        end else begin
                            db_cnt_nx = db_cnt_q + 1'b1;
                        end
                    end else begin
                        state_nx = ST_SCAN;
                    end
                end
            end
            ST_HELD: begin
                if (tick && (row_sync == ROW_IDLE)) begin
                    db_cnt_nx = '0;
                    state_nx  = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (tick) begin
                    if (row_sync == ROW_IDLE) begin
                        if (db_cnt_q == DB_LAST) begin
                            db_cnt_nx = '0;
                            state_nx  = ST_SCAN;
                        end else begin
                            db_cnt_nx = db_cnt_q + 1'b1;
                        end
                    end else begin
                        state_nx = ST_HELD;
                    end
                end
            end
            default: state_nx = ST_SCAN;
        endcase
    end

    // Key output and nibble packing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid  <= 1'b0;
            key_code   <= '0;
            high_q     <= '0;
            half_byte  <= 1'b0;
            data_out   <= '0;
            byte_ready <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            key_valid  <= accept;
            byte_ready <= 1'b0;
            if (accept) begin
                key_code <= {row_idx_q, col_idx_q};
            end
            if (key_valid) begin
                if (!half_byte) begin
                    high_q    <= key_code;
                    half_byte <= 1'b1;
                end else begin
                    data_out   <= {high_q, key_code};
                    half_byte  <= 1'b0;
                    byte_ready <= 1'b1;
                end
            end
            if (byte_ready && fifo_full) begin
                drop_err <= 1'b1;
            end
        end
    end

    assign wr        = byte_ready && !fifo_full;
    assign col_out   = col_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_keypad_writer.sv
module tb_keypad_writer;
    import keypad_writer_pkg::*;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       fifo_full = 1'b0;
    logic       wr;
    logic [7:0] data_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       half_byte;
    logic       drop_err;
    state_t     fsm_state;

    keypad_writer #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .fifo_full (fifo_full),
        .wr        (wr),
        .data_out  (data_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .half_byte (half_byte),
        .drop_err  (drop_err),
        .fsm_state (fsm_state)
    );

    // ---------------- keypad model ----------------
    logic       press_en  = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [1:0] press_col = 2'd0;
    logic       glitch    = 1'b0;

    always_comb begin
        row_in = 4'hF;
        if (glitch) row_in[2] = 1'b0;
        if (press_en && (col_out[press_col] == 1'b0)) row_in[press_row] = 1'b0;
    end

    // ---------------- scoreboard ----------------
    logic [3:0] exp_key_q[$];
    logic [7:0] exp_byte_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int kv_count = 0;
    int wr_count = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                kv_count++;
                n_checks++;
                if (exp_key_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL key_valid_unexpected: key_code=%h, no key expected", key_code);
                end else begin
                    logic [3:0] e;
                    e = exp_key_q.pop_front();
                    if (key_code !== e) begin
                        n_fail++;
                        $display("FAIL key_code: got %h expected %h", key_code, e);
                    end
                end
            end
            if (wr) begin
                wr_count++;
                n_checks++;
                if (exp_byte_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: data_out=%h, no write expected", data_out);
                end else begin
                    logic [7:0] eb;
                    eb = exp_byte_q.pop_front();
                    if (data_out !== eb) begin
                        n_fail++;
                        $display("FAIL data_out: got %h expected %h", data_out, eb);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        press_en = 1'b0;
        glitch = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_key_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: key_valid got 0 expected 1 within 400 cycles", name);
        end
    endtask

    task automatic wait_scan(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (fsm_state == ST_SCAN) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_scan_timeout: state got %0d expected %0d", name, fsm_state, ST_SCAN);
        end
    endtask

    // Press the key at (row, col), hold extra cycles after acceptance, release.
    task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int extra);
        exp_key_q.push_back({r, c});
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
        wait_key_valid("press");
        repeat (extra) @(negedge clk);
        press_en = 1'b0;
        wait_scan("release");
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({col_out, wr, key_valid, key_code, data_out, half_byte, drop_err} !==
            {4'b1110, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: col=%b wr=%b kv=%b key=%h data=%h half=%b drop=%b expected 1110 0 0 0 00 0 0",
                     col_out, wr, key_valid, key_code, data_out, half_byte, drop_err);
        end
        n_checks++;
        if (fsm_state !== ST_SCAN) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_SCAN);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_rotation();
        logic [3:0] prev, exp_col;
        int cnt;
        prev = col_out;
        for (int i = 0; i < 8; i++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (wr) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL idle_wr: got 1 expected 0");
                end
            end while (col_out == prev && cnt < 20);
            exp_col = {prev[2:0], prev[3]};
            n_checks++;
            if (col_out !== exp_col) begin
                n_fail++;
                $display("FAIL scan_col: got %b expected %b", col_out, exp_col);
            end
            if (i > 0) begin
                n_checks++;
                if (cnt != SCAN_DIV) begin
                    n_fail++;
                    $display("FAIL scan_period: got %0d expected %0d", cnt, SCAN_DIV);
                end
            end
            prev = col_out;
        end
        n_checks++;
        if (kv_count != 0) begin
            n_fail++;
            $display("FAIL idle_key_valid: got %0d pulses expected 0", kv_count);
        end
    endtask

    task automatic test_single_key();
        int kv0;
        kv0 = kv_count;
        exp_key_q.push_back(4'hA);
        press_row = 2'd2;
        press_col = 2'd2;
        press_en  = 1'b1;
        wait_key_valid("key_a");
        @(negedge clk);
        n_checks++;
        if (half_byte !== 1'b1) begin
            n_fail++;
            $display("FAIL key_a_half_byte: got %b expected 1", half_byte);
        end
        repeat (10 * SCAN_DIV) @(negedge clk);
        n_checks++;
        if (fsm_state !== ST_HELD) begin
            n_fail++;
            $display("FAIL key_a_held_state: got %0d expected %0d", fsm_state, ST_HELD);
        end
        press_en = 1'b0;
        wait_scan("key_a");
        n_checks++;
        if (kv_count - kv0 != 1) begin
            n_fail++;
            $display("FAIL key_a_no_repeat: got %0d pulses expected 1", kv_count - kv0);
        end
    endtask

    task automatic test_byte_write();
        int wr0;
        wr0 = wr_count;
        fifo_full = 1'b0;
        press_key(2'd0, 2'd3, 5);
        exp_byte_q.push_back(8'h3C);
        press_key(2'd3, 2'd0, 5);
        n_checks++;
        if (wr_count - wr0 != 1) begin
            n_fail++;
            $display("FAIL pair_wr_count: got %0d expected 1", wr_count - wr0);
        end
        n_checks++;
        if (half_byte !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_half_byte: got %b expected 0", half_byte);
        end
        n_checks++;
        if (drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_drop_err: got %b expected 0", drop_err);
        end
    endtask

    task automatic test_fifo_full_drop();
        int wr0;
        wr0 = wr_count;
        fifo_full = 1'b1;
        press_key(2'd0, 2'd3, 5);
        press_key(2'd3, 2'd0, 5);
        n_checks++;
        if (drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_set: got %b expected 1", drop_err);
        end
        n_checks++;
        if (wr_count != wr0) begin
            n_fail++;
            $display("FAIL drop_no_wr: got %0d writes expected 0", wr_count - wr0);
        end
        fifo_full = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_sticky: got %b expected 1", drop_err);
        end
    endtask

    task automatic test_glitch();
        int kv0;
        bit saw_db;
        kv0 = kv_count;
        saw_db = 1'b0;
        glitch = 1'b1;
        repeat (SCAN_DIV) @(negedge clk);
        glitch = 1'b0;
        for (int i = 0; i < 10 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (fsm_state == ST_PRESS_DB) saw_db = 1'b1;
        end
        n_checks++;
        if (!saw_db) begin
            n_fail++;
            $display("FAIL glitch_press_db: got 0 expected 1 (debounce entered)");
        end
        n_checks++;
        if (fsm_state !== ST_SCAN) begin
            n_fail++;
            $display("FAIL glitch_state: got %0d expected %0d", fsm_state, ST_SCAN);
        end
        n_checks++;
        if (kv_count != kv0) begin
            n_fail++;
            $display("FAIL glitch_key_valid: got %0d pulses expected 0", kv_count - kv0);
        end
    endtask

    task automatic test_reset_mid_byte();
        press_key(2'd1, 2'd1, 3);
        n_checks++;
        if (half_byte !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_half_set: got %b expected 1", half_byte);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (half_byte !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_half_clear: got %b expected 0", half_byte);
        end
        press_key(2'd0, 2'd1, 3);
        exp_byte_q.push_back(8'h12);
        press_key(2'd0, 2'd2, 3);
        n_checks++;
        if (data_out !== 8'h12) begin
            n_fail++;
            $display("FAIL mid_data_out: got %h expected 12", data_out);
        end
    endtask

    task automatic test_drain();
        n_checks++;
        if (exp_key_q.size() != 0 || exp_byte_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d keys %0d bytes outstanding expected 0 0",
                     exp_key_q.size(), exp_byte_q.size());
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_scan_rotation();
        test_single_key();
        do_reset();
        test_byte_write();
        test_fifo_full_drop();
        do_reset();
        test_glitch();
        test_reset_mid_byte();
        repeat (10) @(negedge clk);
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
